// File: rtl/muxpga_cfg_loader_if.sv
// Bus bundle between the pin-side bitstream source and the config loader.
// The master drives the serial stream; the slave (loader) drives the
// committed per-cell configuration and its status strobes.
interface muxpga_cfg_loader_if #(
  parameter int unsigned CELLS = 64,
  parameter int unsigned CFG_W = 5
);
  logic                     din;
  logic                     din_valid;
  logic [CELLS*CFG_W-1:0]   cfg_out;
  logic                     cfg_valid;
  logic                     busy;
  logic                     loaded;
  logic                     err;

  modport master (
    output din,
    output din_valid,
    input  cfg_out,
    input  cfg_valid,
    input  busy,
    input  loaded,
    input  err
  );

  modport slave (
    input  din,
    input  din_valid,
    output cfg_out,
    output cfg_valid,
    output busy,
    output loaded,
    output err
  );
endinterface

// File: rtl/muxpga_cfg_loader.sv
// Serial configuration writer for the mux-based cell array.
// Hunts for a sync byte, stages CELLS words of CFG_W bits (MSB-first),
// then checks an 8-bit additive checksum and commits the staged words to
// cfg_out atomically only on a match. Requires CFG_W >= 2.
module muxpga_cfg_loader #(
  parameter int unsigned CELLS = 64,
  parameter int unsigned CFG_W = 5,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  muxpga_cfg_loader_if.slave  bus
);

  localparam int unsigned TOTAL = CELLS * CFG_W;
  localparam int unsigned BCW   = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int unsigned WCW   = (CELLS > 0) ? $clog2(CELLS + 1) : 1;

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CFG_W - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(CELLS - 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state_q;
  logic [6:0]         win_q;       // last 7 bits seen while hunting
  logic [CFG_W-2:0]   asm_q;       // partially assembled word
  logic [BCW-1:0]     bit_cnt_q;
  logic [WCW-1:0]     word_cnt_q;
  logic [7:0]         sum_q;
  logic [6:0]         rx_q;        // first 7 received checksum bits
  logic [2:0]         ck_cnt_q;
  logic [TOTAL-1:0]   stage_q;
  logic [TOTAL-1:0]   cfg_q;
  logic               cfg_valid_q;
  logic               busy_q;
  logic               loaded_q;
  logic               err_q;

  logic [7:0]         win_d;
  logic [CFG_W-1:0]   word_d;
  logic [7:0]         sum_d;
  logic [7:0]         rx_d;

  // Candidate values including the bit currently on din.
  always_comb begin
    win_d  = {win_q, bus.din};
    word_d = {asm_q, bus.din};
    sum_d  = sum_q + 8'(word_d);
    rx_d   = {rx_q, bus.din};
  end

  // Frame FSM: all state and outputs advance only on valid bits; strobes
  // are single-cycle and self-clear on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      win_q       <= '0;
      asm_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      rx_q        <= '0;
      ck_cnt_q    <= '0;
      stage_q     <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      if (bus.din_valid) begin
        unique case (state_q)
          HUNT: begin
            win_q <= win_d[6:0];
            if (win_d == SYNC) begin
              state_q    <= LOAD;
              busy_q     <= 1'b1;
              asm_q      <= '0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              sum_q      <= '0;
            end
          end
          LOAD: begin
            asm_q <= word_d[CFG_W-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              sum_q     <= sum_d;
              for (int unsigned c = 0; c < CELLS; c++) begin
                if (word_cnt_q == WCW'(c)) begin
                  stage_q[c*CFG_W +: CFG_W] <= word_d;
                end
              end
              if (word_cnt_q == WORD_LAST) begin
                state_q  <= CHECK;
                ck_cnt_q <= '0;
                rx_q     <= '0;
              end else begin
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          CHECK: begin
            rx_q <= rx_d[6:0];
            if (ck_cnt_q == 3'd7) begin
              // Window restarts empty so checksum bits can never combine
              // with the next frame's leading bits into a false sync.
              state_q <= HUNT;
              busy_q  <= 1'b0;
              win_q   <= '0;
              if (rx_d == sum_q) begin
                cfg_q       <= stage_q;
                cfg_valid_q <= 1'b1;
                loaded_q    <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              ck_cnt_q <= ck_cnt_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.cfg_out   = cfg_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.busy      = busy_q;
  assign bus.loaded    = loaded_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Bench for muxpga_cfg_loader: a small (2-cell) and a full (64-cell)
// instance, checked every cycle against a frame-level model that buffers
// the post-sync bits and decodes a whole frame arithmetically.
module tb_muxpga_cfg_loader;
  localparam int unsigned W  = 5;
  localparam int unsigned C0 = 2;
  localparam int unsigned C1 = 64;

  logic clk = 1'b0;
  logic reset;
  logic d0, v0, d1, v1;

  always #5 clk = ~clk;

  muxpga_cfg_loader_if #(.CELLS(C0), .CFG_W(W)) if0 ();
  muxpga_cfg_loader_if #(.CELLS(C1), .CFG_W(W)) if1 ();

  assign if0.din       = d0;
  assign if0.din_valid = v0;
  assign if1.din       = d1;
  assign if1.din_valid = v1;

  muxpga_cfg_loader #(.CELLS(C0), .CFG_W(W), .SYNC(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  muxpga_cfg_loader #(.CELLS(C1), .CFG_W(W), .SYNC(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  int checks   = 0;
  int failures = 0;
  int ld_cnt [2];
  int er_cnt [2];

  // Model state
  logic [7:0]   m_win    [2];
  bit           m_in     [2];
  int           m_n      [2];
  bit           fb       [2][0:335];
  logic [319:0] m_cfg    [2];
  bit           m_valid  [2];
  bit           m_busy   [2];
  bit           m_loaded [2];
  bit           m_err    [2];

  logic [4:0]   wd [64];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic decode(input int i, input int cells);
    logic [319:0] stg;
    logic [4:0]   word;
    int           sum;
    logic [7:0]   rx;
    stg = '0;
    sum = 0;
    for (int k = 0; k < cells; k++) begin
      word = '0;
      for (int b = 0; b < int'(W); b++) word = {word[3:0], fb[i][k*W+b]};
      stg[k*W +: 5] = word;
      sum += int'(word);
    end
    rx = '0;
    for (int b = 0; b < 8; b++) rx = {rx[6:0], fb[i][cells*W+b]};
    if (rx == 8'(sum % 256)) begin
      m_cfg[i]    = stg;
      m_valid[i]  = 1'b1;
      m_loaded[i] = 1'b1;
    end else begin
      m_err[i] = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic v, d;
      int   cells;
      v     = (i == 0) ? v0 : v1;
      d     = (i == 0) ? d0 : d1;
      cells = (i == 0) ? int'(C0) : int'(C1);
      if (reset) begin
        m_win[i] = '0; m_in[i] = 1'b0; m_n[i] = 0; m_cfg[i] = '0;
        m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_loaded[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        m_loaded[i] = 1'b0;
        m_err[i]    = 1'b0;
        if (v) begin
          if (!m_in[i]) begin
            m_win[i] = {m_win[i][6:0], d};
            if (m_win[i] == 8'hA5) begin
              m_in[i] = 1'b1;
              m_n[i]  = 0;
            end
          end else begin
            fb[i][m_n[i]] = d;
            m_n[i]++;
            if (m_n[i] == cells*int'(W) + 8) begin
              decode(i, cells);
              m_in[i]  = 1'b0;
              m_win[i] = '0;
            end
          end
        end
        m_busy[i] = m_in[i];
      end
    end
  endtask

  task automatic compare();
    chk("cfg_out0",   320'(if0.cfg_out), m_cfg[0]);
    chk("cfg_valid0", 320'(if0.cfg_valid), 320'(m_valid[0]));
    chk("busy0",      320'(if0.busy), 320'(m_busy[0]));
    chk("loaded0",    320'(if0.loaded), 320'(m_loaded[0]));
    chk("err0",       320'(if0.err), 320'(m_err[0]));
    chk("cfg_out1",   320'(if1.cfg_out), m_cfg[1]);
    chk("cfg_valid1", 320'(if1.cfg_valid), 320'(m_valid[1]));
    chk("busy1",      320'(if1.busy), 320'(m_busy[1]));
    chk("loaded1",    320'(if1.loaded), 320'(m_loaded[1]));
    chk("err1",       320'(if1.err), 320'(m_err[1]));
    if (if0.loaded === 1'b1) ld_cnt[0]++;
    if (if1.loaded === 1'b1) ld_cnt[1]++;
    if (if0.err === 1'b1) er_cnt[0]++;
    if (if1.err === 1'b1) er_cnt[1]++;
  endtask

  // One clock: apply inputs, compare mid-cycle, step model on the edge.
  task automatic cyc(input int inst, input logic v, input logic b);
    d0 = (inst == 0) ? b : 1'($urandom);
    v0 = (inst == 0) && v;
    d1 = (inst == 1) ? b : 1'($urandom);
    v1 = (inst == 1) && v;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // gm: 0 continuous, 1 valid alternates 1/0, 2 random gaps
  task automatic send_bit(input int inst, input logic b, input int gm);
    if (gm == 2) repeat ($urandom_range(0, 2)) cyc(inst, 1'b0, 1'($urandom));
    cyc(inst, 1'b1, b);
    if (gm == 1) cyc(inst, 1'b0, 1'($urandom));
  endtask

  task automatic send_byte(input int inst, input logic [7:0] by, input int gm);
    for (int b = 7; b >= 0; b--) send_bit(inst, by[b], gm);
  endtask

  task automatic send_frame(input int inst, input int cells, input logic [7:0] cs, input int gm);
    send_byte(inst, 8'hA5, gm);
    for (int k = 0; k < cells; k++)
      for (int b = int'(W) - 1; b >= 0; b--) send_bit(inst, wd[k][b], gm);
    send_byte(inst, cs, gm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_l, base_e;
    int sum;
    logic [7:0] cs;
    d0 = 1'b0; v0 = 1'b0; d1 = 1'b0; v1 = 1'b0;
    ld_cnt = '{0, 0};
    er_cnt = '{0, 0};
    reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    idle(1);
    reset = 1'b0;
    idle(1);
    chk("rst_cfg_out", 320'(if0.cfg_out), 320'h0);
    chk("rst_cfg_valid", 320'(if0.cfg_valid), 320'h0);
    chk("rst_busy", 320'(if1.busy), 320'h0);

    // Test 1: basic frame
    base_l = ld_cnt[0]; base_e = er_cnt[0];
    wd[0] = 5'b11111; wd[1] = 5'b00011;
    send_frame(0, C0, 8'h22, 0);
    idle(3);
    chk("t1_cfg_out", 320'(if0.cfg_out), 320'h07F);
    chk("t1_model_cfg", m_cfg[0], 320'h07F);
    chk("t1_cfg_valid", 320'(if0.cfg_valid), 320'h1);
    chk("t1_loaded_pulses", 320'(ld_cnt[0] - base_l), 320'd1);
    chk("t1_err_pulses", 320'(er_cnt[0] - base_e), 320'd0);

    // Test 2: bad checksum, then good
    do_reset();
    base_l = ld_cnt[0]; base_e = er_cnt[0];
    send_frame(0, C0, 8'h23, 0);
    idle(3);
    chk("t2_err_pulses", 320'(er_cnt[0] - base_e), 320'd1);
    chk("t2_loaded_pulses", 320'(ld_cnt[0] - base_l), 320'd0);
    chk("t2_cfg_out", 320'(if0.cfg_out), 320'h0);
    chk("t2_cfg_valid", 320'(if0.cfg_valid), 320'h0);
    send_frame(0, C0, 8'h22, 0);
    idle(2);
    chk("t2_cfg_out_good", 320'(if0.cfg_out), 320'h07F);

    // Test 3: back-to-back frames, then a bad one
    do_reset();
    send_frame(0, C0, 8'h22, 0);
    wd[0] = 5'b00000; wd[1] = 5'b10101;
    send_frame(0, C0, 8'h15, 0);
    idle(2);
    chk("t3_cfg_out", 320'(if0.cfg_out), 320'h2A0);
    chk("t3_model_cfg", m_cfg[0], 320'h2A0);
    send_frame(0, C0, 8'h16, 0);
    idle(2);
    chk("t3_cfg_out_kept", 320'(if0.cfg_out), 320'h2A0);

    // Test 4: false prefix and alternating valid
    do_reset();
    wd[0] = 5'b11111; wd[1] = 5'b00011;
    send_bit(0, 1'b1, 1); send_bit(0, 1'b0, 1);
    send_bit(0, 1'b1, 1); send_bit(0, 1'b0, 1);
    base_l = ld_cnt[0];
    send_frame(0, C0, 8'h22, 1);
    idle(3);
    chk("t4_cfg_out", 320'(if0.cfg_out), 320'h07F);
    chk("t4_loaded_pulses", 320'(ld_cnt[0] - base_l), 320'd1);

    // Test 5: reset in the middle of LOAD
    do_reset();
    send_byte(0, 8'hA5, 0);
    for (int b = 0; b < 7; b++) send_bit(0, 1'b1, 0);
    chk("t5_busy_mid", 320'(if0.busy), 320'h1);
    do_reset();
    chk("t5_busy_after_rst", 320'(if0.busy), 320'h0);
    chk("t5_cfg_valid_after_rst", 320'(if0.cfg_valid), 320'h0);
    send_frame(0, C0, 8'h22, 0);
    idle(2);
    chk("t5_cfg_out", 320'(if0.cfg_out), 320'h07F);

    // Test 6: full 64-cell frame
    for (int k = 0; k < 64; k++) wd[k] = 5'h1F;
    base_l = ld_cnt[1];
    send_frame(1, C1, 8'hC0, 0);
    idle(3);
    for (int c = 0; c < 64; c++)
      chk("t6_slice", 320'(if1.cfg_out[c*5 +: 5]), 320'h1F);
    chk("t6_loaded_pulses", 320'(ld_cnt[1] - base_l), 320'd1);

    // Randomized frames with gaps, junk prefixes and occasional bad sums
    for (int it = 0; it < 30; it++) begin
      sum = 0;
      for (int k = 0; k < int'(C0); k++) begin
        wd[k] = 5'($urandom);
        sum += int'(wd[k]);
      end
      cs = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(sum % 256);
      repeat ($urandom_range(0, 4)) send_bit(0, 1'($urandom), 2);
      send_frame(0, C0, cs, 2);
      if (it == 17) begin
        send_byte(0, 8'hA5, 2);
        send_bit(0, 1'b1, 2);
        do_reset();
      end
      idle($urandom_range(0, 2));
    end
    for (int it = 0; it < 3; it++) begin
      sum = 0;
      for (int k = 0; k < int'(C1); k++) begin
        wd[k] = 5'($urandom);
        sum += int'(wd[k]);
      end
      cs = (it == 1) ? 8'(sum % 256 + 1) : 8'(sum % 256);
      send_frame(1, C1, cs, 2);
      idle(2);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
